// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the master bridge and slave-side blocks:
// bridge FSM state encoding, default bus widths and the sizing rule for
// the cycle watchdog counter.
`timescale 1ns/1ps

package wb_pkg;

  // Default bus geometry, reusable by slaves that sit on the same bus.
  localparam int DEFAULT_ADDRESS_LENGTH = 32;
  localparam int DEFAULT_DATA_LENGTH    = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  // Bridge FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must hold 0 .. timeout_cycles-1.
  function automatic int wd_count_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int DEFAULT_WD_COUNT_WIDTH = wd_count_width(DEFAULT_TIMEOUT_CYCLES);

endpackage

// File: rtl/wb_watchdog.sv
// Bus-cycle watchdog: counts cycles spent waiting for ack and flags
// expiry once TIMEOUT_CYCLES-1 un-acked cycles have elapsed, so the
// TIMEOUT_CYCLES-th waiting cycle is the last one before abort.
// Only instantiated when the bridge is built with WB_TIMEOUT_EN.
`timescale 1ns/1ps

module wb_watchdog
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = wd_count_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Counter clears when a new bus cycle starts and advances on each
  // un-acked cycle; it parks at LAST_COUNT so it can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST_COUNT);

endmodule

// File: rtl/wb_master_bridge.sv
// Wishbone classic-cycle master. Turns single-transfer core requests into
// bus cycles, waits for ack, captures read data and returns a one-cycle
// done pulse. All outputs are registered.
// Optional feature macro: WB_TIMEOUT_EN -- builds a watchdog that aborts
// a bus cycle with err=1 after TIMEOUT_CYCLES cycles without ack.
`timescale 1ns/1ps

module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int ADDRESS_LENGTH = DEFAULT_ADDRESS_LENGTH,
  parameter int DATA_LENGTH    = DEFAULT_DATA_LENGTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  // core side
  input  logic                      req,
  input  logic                      req_we,
  input  logic [ADDRESS_LENGTH-1:0] req_addr,
  input  logic [DATA_LENGTH-1:0]    req_wdata,
  output logic                      ready,
  output logic                      done,
  output logic                      err,
  output logic [DATA_LENGTH-1:0]    rdata,
  // Wishbone side
  output logic                      cyc,
  output logic                      stb,
  output logic                      we,
  output logic [ADDRESS_LENGTH-1:0] ADR_O,
  output logic [DATA_LENGTH-1:0]    DAT_O,
  input  logic [DATA_LENGTH-1:0]    DAT_I,
  input  logic                      ack
);

  // A one-cycle watchdog window would abort before the slave could answer.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("wb_master_bridge: TIMEOUT_CYCLES must be at least 2");
  end

  state_t state;
  state_t state_next;

  logic accept;        // request taken in IDLE this cycle
  logic ack_take;      // first ack of the current bus cycle
  logic timeout_take;  // watchdog abort with no ack this cycle
  logic expired;       // watchdog limit reached

`ifdef WB_TIMEOUT_EN
  wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept),
    .en     ((state == BUS) && !ack),
    .expired(expired)
  );
`else
  // Without the watchdog a bus cycle waits for ack indefinitely.
  assign expired = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and transfer-event decode; ack beats a simultaneous timeout.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_next   = state;
    accept       = 1'b0;
    ack_take     = 1'b0;
    timeout_take = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept     = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        if (ack) begin
          ack_take   = 1'b1;
          state_next = DONE;
        end else if (expired) begin
          timeout_take = 1'b1;
          state_next   = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs: handshake flags follow the next state, bus
  // attributes latch on accept and hold afterwards, rdata loads on read ack.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the datapath registers are few and have defined reset values,
    // so they are all cleared here; no storage array is involved.
    if (reset) begin
      ready <= 1'b1;
      done  <= 1'b0;
      cyc   <= 1'b0;
      stb   <= 1'b0;
      we    <= 1'b0;
      ADR_O <= '0;
      DAT_O <= '0;
      rdata <= '0;
    end else begin
      ready <= (state_next == IDLE);
      done  <= (state == BUS) && (state_next == DONE);
      cyc   <= (state_next == BUS);
      stb   <= (state_next == BUS);
      if (accept) begin
        we    <= req_we;
        ADR_O <= req_addr;
        DAT_O <= req_wdata;
      end
      if (ack_take && !we) begin
        rdata <= DAT_I;
      end
    end
  end

`ifdef WB_TIMEOUT_EN
  // err qualifies the done pulse: set only when the cycle was aborted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= timeout_take;
    end
  end
`else
  // Cycles can only end by ack, so err is never raised.
  assign err = 1'b0;
`endif

endmodule

// File: doc/wb_master_bridge.md
# wb_master_bridge

Wishbone classic-cycle master that converts the multicycle core's single-transfer memory requests into bus cycles for the Wishbone slave interface downstream. It drives `cyc`/`stb`/`we`, the address and the write data, waits for `ack`, captures read data and returns a one-cycle completion pulse to the core. An optional watchdog aborts cycles that never receive `ack`.

## Interface
Parameters:
- `ADDRESS_LENGTH`, 32: bus address width.
- `DATA_LENGTH`, 32: bus data width.
- `TIMEOUT_CYCLES`, 16: cycles in BUS without `ack` before abort; only used with `WB_TIMEOUT_EN`; must be ≥ 2.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in 1: core request; sampled only in IDLE.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDRESS_LENGTH: transfer address.
- `req_wdata` in DATA_LENGTH: write data.
- `ready` out 1: high in IDLE; request accepted.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; 1 = timed-out cycle.
- `rdata` out DATA_LENGTH: last captured read data; held between reads.
- `cyc`, `stb`, `we` out 1: Wishbone cycle, strobe and write enable.
- `ADR_O` out ADDRESS_LENGTH: bus address.
- `DAT_O` out DATA_LENGTH: bus write data.
- `DAT_I` in DATA_LENGTH: bus read data.
- `ack` in 1: slave acknowledge.

## Operation
- States: IDLE, BUS, DONE (2-bit encoding).
- IDLE: `ready`=1. When `req`=1:
  - latch `req_we`→`we`, `req_addr`→`ADR_O` and `req_wdata`→`DAT_O`;
  - set `cyc`=`stb`=1 and go to BUS.
- BUS: `cyc`=`stb`=1. `ADR_O`, `DAT_O` and `we` stay stable for the whole cycle. When `ack`=1:
  - if `we`=0, capture `DAT_I`→`rdata`;
  - clear `cyc`/`stb`, set `err`=0 and go to DONE.
- DONE: `done`=1 for exactly one cycle, `ready`=0, then return to IDLE.
- `req` outside IDLE is ignored; the core must hold or re-issue it.
- `ack` outside BUS is ignored.
- `ADR_O`, `DAT_O` and `we` keep their last values after the cycle ends. `we` stays registered; it is not forced to 0.
- Every output is registered; there are no combinational paths from input to output.

## Timing
- Reset values: state=IDLE, `ready`=1, `done`=0, `err`=0, `cyc`=0, `stb`=0, `we`=0, `ADR_O`=0, `DAT_O`=0, `rdata`=0.
- `req` sampled high at edge N: `cyc`/`stb` are high from N+1.
- `ack` sampled high at edge M: `cyc`/`stb` are low and `done` is high from M+1. `ready` is high again from M+2.
- Minimum transaction: `req`→`done` = 2 cycles with zero-wait `ack`. Back-to-back throughput is one transfer per 3 cycles.
- Reset asserted mid-cycle: `cyc`/`stb` drop immediately, with no `done` and no `rdata` update.
- Multi-cycle `ack` from the slave: only the first sampled `ack` counts. The extra `ack` arrives in DONE and is ignored.

## Configuration
- `WB_TIMEOUT_EN` defined:
  - a watchdog counter clears on entry to BUS and increments each BUS cycle without `ack`;
  - when the count reaches `TIMEOUT_CYCLES`-1 without `ack`, `cyc`/`stb` drop, the FSM goes to DONE with `err`=1 and `rdata` is left unchanged;
  - if `ack` and timeout occur in the same cycle, `ack` wins (`err`=0, data captured).
- Macro undefined: no counter is built, `err` is tied to 0 and BUS waits indefinitely.

## Structure
- Shared package `wb_pkg`:
  - state enum (IDLE/BUS/DONE);
  - the `clog2`-based width of the timeout counter;
  - shared Wishbone constants (e.g. default widths), reusable by the slave side.
- Sub-module `wb_watchdog`:
  - ports: `clk`, `reset`, `clr`, `en`, `expired`;
  - parameterised by `TIMEOUT_CYCLES`;
  - instantiated only under `WB_TIMEOUT_EN`.
- FSM and datapath registers stay in `wb_master_bridge`.

## Test plan
- Write, zero-wait: `req`=1, `req_we`=1, `req_addr`=0x0000_0010, `req_wdata`=0xDEAD_BEEF; slave `ack` in the first BUS cycle → `cyc`/`stb`/`we` high for 1 cycle with `ADR_O`=0x10 and `DAT_O`=0xDEADBEEF; `done`=1, `err`=0 two cycles after `req`.
- Read, 3 wait states: `req_we`=0, addr 0x20; `ack` on the 4th BUS cycle with `DAT_I`=0x1234_5678 → `cyc` high for 4 cycles; `rdata`=0x12345678 when `done`=1.
- Request while busy: second `req` with addr 0x40 asserted during BUS and DONE → ignored; accepted only at the next IDLE cycle; the first transfer's `ADR_O` stays 0x20 throughout.
- Reset mid-cycle: assert `reset` in the 2nd BUS cycle → `cyc`=`stb`=0 immediately; all outputs at reset values; no `done`.
- Timeout (`WB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): never `ack` → `cyc` high exactly 16 cycles, then `done`=1, `err`=1, `rdata` unchanged. With `ack` in the 16th cycle → `err`=0 and data captured.
- Macro off: never `ack` for 100 cycles → `cyc` stays high and `done` stays 0.
